// File: rtl/ift_sram_arb_mem.sv
// Single-bank SRAM shared by NumPorts OBI-style requesters with round-robin arbitration,
// a ReadLatency-deep response pipeline and a bitwise shadow taint array kept beside the data.
module ift_sram_arb_mem #(
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned Width       = 32,
  parameter int unsigned Depth       = 1 << 16,
  parameter int unsigned ReadLatency = 1,
  parameter logic [31:0] BaseAddr    = 32'h80000000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumPorts-1:0]       req_i,
  input  logic [NumPorts-1:0]       we_i,
  input  logic [NumPorts*32-1:0]    addr_i,
  input  logic [NumPorts*Width-1:0] wdata_i,
  input  logic [NumPorts*Width-1:0] strb_i,
  output logic [NumPorts-1:0]       gnt_o,
  output logic [NumPorts-1:0]       rvalid_o,
  output logic [NumPorts*Width-1:0] rdata_o,
  output logic [NumPorts-1:0]       err_o,
  input  logic [NumPorts-1:0]       req_i_t0,
  input  logic [NumPorts-1:0]       we_i_t0,
  input  logic [NumPorts*32-1:0]    addr_i_t0,
  input  logic [NumPorts*Width-1:0] wdata_i_t0,
  input  logic [NumPorts*Width-1:0] strb_i_t0,
  output logic [NumPorts-1:0]       gnt_o_t0,
  output logic [NumPorts-1:0]       rvalid_o_t0,
  output logic [NumPorts-1:0]       err_o_t0,
  output logic [NumPorts*Width-1:0] rdata_o_t0
);
  localparam int unsigned PW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned AW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned LAST = ReadLatency - 1;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    cand;
  logic             found;
  logic             fire;
  logic             we_g;
  logic             we_t_g;
  logic [31:0]      addr_g;
  logic [31:0]      addr_t_g;
  logic [31:0]      off;
  logic [Width-1:0] wdata_g;
  logic [Width-1:0] wdata_t_g;
  logic [Width-1:0] strb_g;
  logic [Width-1:0] strb_t_g;
  logic             in_range;
  logic [AW-1:0]    midx;
  logic             a_taint;
  logic             w_taint;
  logic             g_taint;
  logic [Width-1:0] mem_rd;
  logic [Width-1:0] sh_rd;

  logic [Width-1:0] mem    [Depth];
  logic [Width-1:0] shadow [Depth];

  logic             vld_p   [ReadLatency];
  logic [PW-1:0]    port_p  [ReadLatency];
  logic             err_p   [ReadLatency];
  logic [Width-1:0] data_p  [ReadLatency];
  logic [Width-1:0] taint_p [ReadLatency];
  logic             vt_p    [ReadLatency];
  logic             et_p    [ReadLatency];

  // Arbitration: first requester at or after ptr, wrapping
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cand = PW'((32'(ptr) + i) % NumPorts);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign fire = found & rst_ni;

  always_comb begin
    gnt_o = '0;
    if (fire) gnt_o[sel] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (32'(sel) == NumPorts - 1) ? '0 : sel + 1'b1;
    end
  end

  assign we_g      = we_i[sel];
  assign we_t_g    = we_i_t0[sel];
  assign addr_g    = addr_i[32*sel +: 32];
  assign addr_t_g  = addr_i_t0[32*sel +: 32];
  assign wdata_g   = wdata_i[Width*sel +: Width];
  assign wdata_t_g = wdata_i_t0[Width*sel +: Width];
  assign strb_g    = strb_i[Width*sel +: Width];
  assign strb_t_g  = strb_i_t0[Width*sel +: Width];

  assign off      = addr_g - BaseAddr;
  assign in_range = (addr_g >= BaseAddr) && ((off >> 2) < 32'(Depth));
  assign midx     = AW'(off >> 2);
  assign a_taint  = |addr_t_g;
  assign w_taint  = a_taint | we_t_g;
  assign g_taint  = (|req_i) & (|req_i_t0);
  assign gnt_o_t0 = {NumPorts{g_taint}};

  assign mem_rd = mem[midx];
  assign sh_rd  = shadow[midx];

  // Grant edge: masked write of data and taint; out-of-range writes are dropped
  always_ff @(posedge clk_i) begin
    if (fire && we_g && in_range) begin
      mem[midx]    <= (wdata_g & strb_g) | (mem_rd & ~strb_g);
      shadow[midx] <= ((wdata_t_g | {Width{w_taint}}) & strb_g) | (sh_rd & ~strb_g) | strb_t_g;
    end
  end

  // Response stage p0 captured at the grant edge, shifted through to p[LAST]
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ReadLatency; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= fire;
      for (int i = 1; i < ReadLatency; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    port_p[0]  <= sel;
    err_p[0]   <= ~in_range;
    data_p[0]  <= (we_g || !in_range) ? '0 : mem_rd;
    taint_p[0] <= we_g ? '0 : ((in_range ? sh_rd : '0) | {Width{a_taint}});
    vt_p[0]    <= g_taint;
    et_p[0]    <= g_taint | a_taint;
    for (int i = 1; i < ReadLatency; i++) begin
      port_p[i]  <= port_p[i-1];
      err_p[i]   <= err_p[i-1];
      data_p[i]  <= data_p[i-1];
      taint_p[i] <= taint_p[i-1];
      vt_p[i]    <= vt_p[i-1];
      et_p[i]    <= et_p[i-1];
    end
  end

  // Output stage: only the responding port sees non-zero data
  always_comb begin
    rvalid_o    = '0;
    err_o       = '0;
    rdata_o     = '0;
    rdata_o_t0  = '0;
    rvalid_o_t0 = '0;
    err_o_t0    = '0;
    if (vld_p[LAST]) begin
      rvalid_o[port_p[LAST]]                  = 1'b1;
      err_o[port_p[LAST]]                     = err_p[LAST];
      rdata_o[Width*port_p[LAST] +: Width]    = data_p[LAST];
      rdata_o_t0[Width*port_p[LAST] +: Width] = taint_p[LAST];
      rvalid_o_t0                             = {NumPorts{vt_p[LAST]}};
      err_o_t0                                = {NumPorts{vt_p[LAST]}};
      err_o_t0[port_p[LAST]]                  = et_p[LAST];
    end
  end

endmodule

// File: tb/tb_ift_sram_arb_mem.sv
// Bench for ift_sram_arb_mem: two instances (read latency 1 and 3) share stimulus and are
// checked every cycle against a transaction-level scoreboard, plus a directed vector table.
module tb_ift_sram_arb_mem;
  localparam int NP = 2;
  localparam int W = 32;
  localparam int DEPTH = 1 << 16;
  localparam logic [31:0] BASE = 32'h80000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [NP-1:0]   req, we, req_t, we_t;
  logic [NP*32-1:0] addr, addr_t;
  logic [NP*W-1:0] wdata, strb, wdata_t, strb_t;

  logic [NP-1:0]   gnt1, rv1, err1, gt1, rvt1, et1;
  logic [NP*W-1:0] rd1, rdt1;
  logic [NP-1:0]   gnt3, rv3, err3, gt3, rvt3, et3;
  logic [NP*W-1:0] rd3, rdt3;

  ift_sram_arb_mem #(.NumPorts(NP), .Width(W), .Depth(DEPTH), .ReadLatency(1), .BaseAddr(BASE)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .strb_i(strb), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1),
    .req_i_t0(req_t), .we_i_t0(we_t), .addr_i_t0(addr_t), .wdata_i_t0(wdata_t),
    .strb_i_t0(strb_t), .gnt_o_t0(gt1), .rvalid_o_t0(rvt1), .err_o_t0(et1), .rdata_o_t0(rdt1));

  ift_sram_arb_mem #(.NumPorts(NP), .Width(W), .Depth(DEPTH), .ReadLatency(3), .BaseAddr(BASE)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .strb_i(strb), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3), .err_o(err3),
    .req_i_t0(req_t), .we_i_t0(we_t), .addr_i_t0(addr_t), .wdata_i_t0(wdata_t),
    .strb_i_t0(strb_t), .gnt_o_t0(gt3), .rvalid_o_t0(rvt3), .err_o_t0(et3), .rdata_o_t0(rdt3));

  typedef struct {
    bit v; int port; bit err; logic [31:0] d; logic [31:0] dt; bit vt; bit et;
  } rsp_t;

  typedef struct {
    logic we; logic [31:0] a; logic [31:0] wd; logic [31:0] s; logic [31:0] wt;
    logic [31:0] st; logic [31:0] at; logic wet;
    logic e_err; logic [31:0] e_rd; logic [31:0] e_rdt;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mptr = 0;
  int last_g;
  logic [31:0] mmem [int];
  logic [31:0] msh [int];
  rsp_t due1 [int];
  rsp_t due3 [int];
  logic [1:0] gnt_h [int];
  logic [1:0] gt_h [int];
  logic [1:0] rv1_h [int];
  logic [1:0] rv3_h [int];
  logic [1:0] rvt1_h [int];
  logic [1:0] rvt3_h [int];
  bit got1, got3, cerr1, cerr3;
  logic [31:0] crd1, crdt1, crd3, crdt3;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic rsp_t access(input int g);
    rsp_t r;
    logic [31:0] a, off, wd, s, wt, st, old, sh;
    bit inr, at, A;
    int idx;
    a   = addr[g*32 +: 32];
    off = a - BASE;
    inr = (a >= BASE) && ((off >> 2) < DEPTH);
    idx = int'(off >> 2);
    at  = |addr_t[g*32 +: 32];
    A   = at | we_t[g];
    wd  = wdata[g*W +: W];
    s   = strb[g*W +: W];
    wt  = wdata_t[g*W +: W];
    st  = strb_t[g*W +: W];
    old = mmem.exists(idx) ? mmem[idx] : 32'h0;
    sh  = msh.exists(idx) ? msh[idx] : 32'h0;
    r.v = 1; r.port = g; r.err = !inr;
    r.vt = (req_t != 0); r.et = r.vt | at;
    if (we[g]) begin
      r.d = 0; r.dt = 0;
      if (inr) begin
        for (int b = 0; b < 32; b++) begin
          if (s[b]) begin
            old[b] = wd[b];
            sh[b] = wt[b] | A;
          end
          sh[b] = sh[b] | st[b];
        end
        mmem[idx] = old;
        msh[idx] = sh;
      end
    end else begin
      r.d  = inr ? old : 32'h0;
      r.dt = (inr ? sh : 32'h0) | {32{at}};
    end
    return r;
  endfunction

  task automatic check_rsp(input string nm, input rsp_t r, input logic [1:0] rv, input logic [1:0] er,
                           input logic [63:0] rd, input logic [63:0] rdt, input logic [1:0] rvt,
                           input logic [1:0] ert);
    logic [1:0] e_rv, e_er, e_rvt, e_ert;
    logic [63:0] e_rd, e_rdt;
    e_rv = 0; e_er = 0; e_rvt = 0; e_ert = 0; e_rd = 0; e_rdt = 0;
    if (r.v) begin
      e_rv  = 2'(1 << r.port);
      e_er  = r.err ? e_rv : 2'b00;
      e_rd  = 64'(r.d) << (32 * r.port);
      e_rdt = 64'(r.dt) << (32 * r.port);
      e_rvt = r.vt ? 2'b11 : 2'b00;
      e_ert = e_rvt | (r.et ? e_rv : 2'b00);
    end
    check({nm, "_rvalid"}, rv, e_rv);
    check({nm, "_err"}, er, e_er);
    check({nm, "_rdata"}, rd, e_rd);
    check({nm, "_rdata_t0"}, rdt, e_rdt);
    check({nm, "_rvalid_t0"}, rvt, e_rvt);
    check({nm, "_err_t0"}, ert, e_ert);
  endtask

  task automatic tick();
    int g, p;
    rsp_t r, none;
    none = '{v: 0, port: 0, err: 0, d: 0, dt: 0, vt: 0, et: 0};
    @(negedge clk);
    g = -1;
    if (rst_n && req != 0) begin
      for (int k = 0; k < NP; k++) begin
        p = (mptr + k) % NP;
        if (g < 0 && req[p]) g = p;
      end
    end
    check("gnt_rl1", gnt1, (g < 0) ? 2'b00 : 2'(1 << g));
    check("gnt_rl3", gnt3, (g < 0) ? 2'b00 : 2'(1 << g));
    check("gnt_t0", gt1, (req != 0 && req_t != 0) ? 2'b11 : 2'b00);
    check("gnt_t0_rl3", gt3, gt1);
    r = due1.exists(cyc) ? due1[cyc] : none;
    check_rsp("rl1", r, rv1, err1, rd1, rdt1, rvt1, et1);
    r = due3.exists(cyc) ? due3[cyc] : none;
    check_rsp("rl3", r, rv3, err3, rd3, rdt3, rvt3, et3);
    gnt_h[cyc] = gnt1; gt_h[cyc] = gt1;
    rv1_h[cyc] = rv1; rv3_h[cyc] = rv3; rvt1_h[cyc] = rvt1; rvt3_h[cyc] = rvt3;
    if (rv1[0]) begin got1 = 1; crd1 = rd1[31:0]; crdt1 = rdt1[31:0]; cerr1 = err1[0]; end
    if (rv3[0]) begin got3 = 1; crd3 = rd3[31:0]; crdt3 = rdt3[31:0]; cerr3 = err3[0]; end
    due1.delete(cyc); due3.delete(cyc);
    if (!rst_n) begin
      mptr = 0;
      for (int k = 1; k <= 3; k++) begin due1.delete(cyc + k); due3.delete(cyc + k); end
    end else if (g >= 0) begin
      r = access(g);
      due1[cyc + 1] = r;
      due3[cyc + 3] = r;
      mptr = (g + 1) % NP;
    end
    last_g = g;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    req = 0; we = 0; addr = 0; wdata = 0; strb = 0;
    req_t = 0; we_t = 0; addr_t = 0; wdata_t = 0; strb_t = 0;
  endtask

  task automatic txn(input vec_t v);
    idle_inputs();
    req[0] = 1'b1; we[0] = v.we; addr[31:0] = v.a; wdata[31:0] = v.wd; strb[31:0] = v.s;
    wdata_t[31:0] = v.wt; strb_t[31:0] = v.st; addr_t[31:0] = v.at; we_t[0] = v.wet;
    got1 = 0; got3 = 0;
    tick();
    idle_inputs();
    repeat (3) tick();
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] s, input logic [31:0] wt, input logic [31:0] st,
                              input logic [31:0] at, input logic wet, input logic e_err,
                              input logic [31:0] e_rd, input logic [31:0] e_rdt);
    vec_t v;
    v.we = w; v.a = a; v.wd = wd; v.s = s; v.wt = wt; v.st = st; v.at = at; v.wet = wet;
    v.e_err = e_err; v.e_rd = e_rd; v.e_rdt = e_rdt;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic pend [NP];
    logic pwe [NP];
    logic [31:0] pa [NP];
    logic [31:0] pwd [NP];
    logic [31:0] ps [NP];
    logic [31:0] pwt [NP];
    logic [31:0] pst [NP];
    logic [31:0] pat [NP];
    logic pwet [NP];
    int c0, sel;
    logic [1:0] e;

    tbl.push_back(mk(1, 32'h80000000, 32'h0BADF00D, '1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h8003FFFC, 32'hCAFEF00D, '1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h80000020, 32'hA5A5A5A5, '1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h80000030, 32'h00000000, '1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h80000040, 32'h55555555, '1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h80000010, 32'hDEADBEEF, '1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h80000020, 32'h12345678, 32'h0000FFFF, 32'h000000FF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h80000020, 0, 0, 0, 0, 0, 0, 0, 32'hA5A55678, 32'h000000FF));
    tbl.push_back(mk(1, 32'h80000020, 32'h11000000, 32'hFF000000, 0, 0, 32'h00000010, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h80000020, 0, 0, 0, 0, 0, 0, 0, 32'h11A55678, 32'hFF0000FF));
    tbl.push_back(mk(0, 32'h7FFFFFFC, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h80040000, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'h80040000, 32'hFFFFFFFF, '1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'h7FFFFFFC, 32'hFFFFFFFF, '1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D, 0));
    tbl.push_back(mk(0, 32'h8003FFFC, 0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 32'h80000010, 0, 0, 0, 0, 32'h00000001, 0, 0, 32'hDEADBEEF, 32'hFFFFFFFF));
    tbl.push_back(mk(1, 32'h80000030, 32'hFFFFFFFF, 0, 0, 32'h0000F000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h80000030, 0, 0, 0, 0, 0, 0, 0, 32'h00000000, 32'h0000F000));
    tbl.push_back(mk(1, 32'h80000040, 32'h000000AA, 32'h000000FF, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h80000040, 0, 0, 0, 0, 0, 0, 0, 32'h555555AA, 32'h000000FF));
    tbl.push_back(mk(0, 32'h7FFFFFFC, 0, 0, 0, 0, 32'h80000000, 0, 1, 0, 32'hFFFFFFFF));

    idle_inputs();
    rst_n = 0;
    req = 2'b11;
    repeat (3) tick();
    idle_inputs();
    rst_n = 1;
    tick();

    foreach (tbl[i]) begin
      txn(tbl[i]);
      check($sformatf("tbl%0d_rv_rl1", i), got1, 1);
      check($sformatf("tbl%0d_rv_rl3", i), got3, 1);
      check($sformatf("tbl%0d_err", i), {cerr1, cerr3}, {tbl[i].e_err, tbl[i].e_err});
      check($sformatf("tbl%0d_rdata", i), {crd1, crd3}, {tbl[i].e_rd, tbl[i].e_rd});
      check($sformatf("tbl%0d_rdata_t0", i), {crdt1, crdt3}, {tbl[i].e_rdt, tbl[i].e_rdt});
    end

    // Round-robin under continuous contention, with a tainted request on the third cycle.
    rst_n = 0; tick(); rst_n = 1;
    req = 2'b11;
    addr = {32'h80000020, 32'h80000010};
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      req_t = (k == 2) ? 2'b10 : 2'b00;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr_gnt%0d", k), gnt_h[c0 + k], e);
      check($sformatf("rr_rv1_%0d", k), rv1_h[c0 + k + 1], e);
      check($sformatf("rr_rv3_%0d", k), rv3_h[c0 + k + 3], e);
    end
    check("rr_gnt_t0", gt_h[c0 + 2], 2'b11);
    check("rr_rvt_rl1", rvt1_h[c0 + 3], 2'b11);
    check("rr_rvt_rl3", rvt3_h[c0 + 5], 2'b11);
    check("rr_rvt_clean", rvt1_h[c0 + 2], 2'b00);

    // Reset one cycle after a latency-3 read grant; a write offered during reset must not land.
    idle_inputs();
    req[0] = 1; addr[31:0] = 32'h80000010;
    c0 = cyc;
    tick();
    rst_n = 0;
    we[0] = 1; wdata[31:0] = 32'h01234567; strb[31:0] = '1;
    tick();
    rst_n = 1;
    idle_inputs();
    repeat (3) tick();
    check("rst_rv1_before", rv1_h[c0 + 1], 2'b01);
    check("rst_gnt_during", gnt_h[c0 + 1], 2'b00);
    check("rst_rv3_dropped", rv3_h[c0 + 3], 2'b00);
    c0 = cyc;
    txn(mk(0, 32'h80000010, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst_gnt_resume", gnt_h[c0], 2'b01);
    check("rst_readback", {got1, got3, crd1, crd3}, {1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF});

    // Randomized traffic from both ports against the scoreboard.
    for (int i = 0; i < 16; i++) txn(mk(1, BASE + 32'(4 * i), $urandom, '1, 0, 0, 0, 0, 0, 0, 0));
    for (int p = 0; p < NP; p++) pend[p] = 0;
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1;
          pwe[p] = 1'($urandom_range(0, 1));
          sel = $urandom_range(0, 9);
          if (sel == 0) pa[p] = 32'h7FFFFFF0 + 32'(4 * $urandom_range(0, 3));
          else if (sel == 1) pa[p] = 32'h80040000 + 32'(4 * $urandom_range(0, 15));
          else pa[p] = BASE + 32'(4 * $urandom_range(0, 15));
          pwd[p] = $urandom;
          ps[p] = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
          pwt[p] = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
          pst[p] = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
          pat[p] = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
          pwet[p] = ($urandom_range(0, 7) == 0);
        end
        req[p] = pend[p];
        we[p] = pwe[p]; addr[p*32 +: 32] = pa[p]; wdata[p*W +: W] = pwd[p];
        strb[p*W +: W] = ps[p]; wdata_t[p*W +: W] = pwt[p]; strb_t[p*W +: W] = pst[p];
        addr_t[p*32 +: 32] = pat[p]; we_t[p] = pwet[p];
        req_t[p] = ($urandom_range(0, 9) == 0);
      end
      rst_n = ($urandom_range(0, 59) != 0);
      tick();
      if (last_g >= 0) pend[last_g] = 0;
    end
    rst_n = 1;
    idle_inputs();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
